// File: rtl/feature_tx_pkg.sv
// -----------------------------------------------------------------------------
// feature_tx_pkg
// Shared definitions for the feature TX controller: FSM state encoding,
// header magic, header field offsets, word-count width and a helper that
// assembles the 64-bit packet header word.
// -----------------------------------------------------------------------------
package feature_tx_pkg;

  localparam int CNT_W = 13;
  localparam int IDX_W = 16;

  localparam logic [15:0] HDR_MAGIC_DEF = 16'hA55A;

  // Header layout: {magic[63:48], pkt_idx[47:32], 3'b0, pkt_len[28:16], 3'b0, remaining[12:0]}
  localparam int HDR_MAGIC_LSB = 48;
  localparam int HDR_IDX_LSB   = 32;
  localparam int HDR_LEN_LSB   = 16;
  localparam int HDR_REM_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_LOAD,
    ST_HDR,
    ST_PAYLOAD,
    ST_DONE
  } tx_state_e;

  function automatic logic [63:0] build_hdr(input logic [15:0]      magic,
                                            input logic [IDX_W-1:0] idx,
                                            input logic [CNT_W-1:0] len,
                                            input logic [CNT_W-1:0] rem);
    logic [63:0] w;
    w = '0;
    w[HDR_MAGIC_LSB +: 16]    = magic;
    w[HDR_IDX_LSB   +: IDX_W] = idx;
    w[HDR_LEN_LSB   +: CNT_W] = len;
    w[HDR_REM_LSB   +: CNT_W] = rem;
    return w;
  endfunction

endpackage

// File: rtl/feature_tx_ctrl_if.sv
// -----------------------------------------------------------------------------
// feature_tx_ctrl_if
// Valid/ready stream carrying packetised feature words towards the UDP TX path.
//   tx_data  : stream word
//   tx_valid : word present
//   tx_last  : final payload word of the current packet
//   tx_ready : consumer accepts the word this cycle
// master = producer (feature_tx_ctrl), slave = consumer.
// -----------------------------------------------------------------------------
interface feature_tx_ctrl_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/feature_tx_ctrl_skid_fifo2.sv
// -----------------------------------------------------------------------------
// tx_skid_fifo2
// Two-entry FIFO of {data, last} that decouples the buffer read pipeline from
// downstream backpressure. Output word stays put until popped.
//   sclk, s_rst_n      : clock, asynchronous active-low reset
//   push/push_data/push_last : write one entry (caller never pushes when full)
//   pop                : remove head entry (ignored when empty)
//   out_valid/out_data/out_last : head entry, zero when empty
//   occupancy          : number of stored entries (0..2)
// -----------------------------------------------------------------------------
module tx_skid_fifo2 #(
  parameter int DATA_W = 64
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] mem_data [2];
  logic              mem_last [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        cnt;
  logic              pop_ok;

  assign pop_ok    = pop & (cnt != 2'd0);
  assign out_valid = (cnt != 2'd0);
  assign occupancy = cnt;
  // Gate with valid so an empty buffer (including right after reset) drives zeros.
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_last  = out_valid & mem_last[rd_ptr];

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop_ok;
      case ({push, pop_ok})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_last[wr_ptr] <= push_last;
    end
  end

endmodule

// File: rtl/feature_tx_ctrl.sv
// -----------------------------------------------------------------------------
// feature_tx_ctrl
// Drains one frame from the feature TX buffer and packetises it into a
// valid/ready stream: per packet one header word, then up to MAX_PKT_WORDS
// payload words.
//   sclk, s_rst_n     : clock, asynchronous active-low reset
//   frame_done        : pulse, a complete frame sits in the buffer
//   read_start        : pulse to the buffer, snapshot its data_count
//   buffer_data_count : snapshot, valid the cycle after read_start
//   buffer_rd_en      : FIFO read strobe
//   buffer_rd_data    : FIFO word, valid one cycle after buffer_rd_en
//   tx                : output stream (master side)
//   busy              : frame in progress
//   frame_sent        : pulse, whole frame handed downstream
// -----------------------------------------------------------------------------
module feature_tx_ctrl
  import feature_tx_pkg::*;
#(
  parameter int          DATA_W        = 64,
  parameter int          MAX_PKT_WORDS = 128,
  parameter logic [15:0] HDR_MAGIC     = HDR_MAGIC_DEF
) (
  input  logic               sclk,
  input  logic               s_rst_n,
  input  logic               frame_done,
  output logic               read_start,
  input  logic [CNT_W-1:0]   buffer_data_count,
  output logic               buffer_rd_en,
  input  logic [DATA_W-1:0]  buffer_rd_data,
  feature_tx_ctrl_if.master  tx,
  output logic               busy,
  output logic               frame_sent
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_PKT_WORDS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  tx_state_e         state;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  pkt_len;
  logic [CNT_W-1:0]  issued;
  logic [IDX_W-1:0]  pkt_idx;
  logic              rd_vld_p1;
  logic              rd_last_p1;

  logic              in_hdr;
  logic              in_pay;
  logic [CNT_W-1:0]  hdr_len;
  logic [CNT_W-1:0]  cur_len;
  logic [CNT_W-1:0]  cur_issued;
  logic [1:0]        occ;
  logic              pop;
  logic [2:0]        room;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              push_last;
  logic              last_acc;

  assign in_hdr  = (state == ST_HDR);
  assign in_pay  = (state == ST_PAYLOAD);
  assign hdr_len = (remaining < MAX_LEN) ? remaining : MAX_LEN;

  // The HDR cycle already counts as the packet's first issue slot, before
  // pkt_len/issued are registered.
  assign cur_len    = in_hdr ? hdr_len : pkt_len;
  assign cur_issued = in_hdr ? '0 : issued;

  assign pop = tx.tx_valid & tx.tx_ready;

  // Skid entries held at the end of this cycle if nothing else is read:
  // current occupancy, minus the word leaving now, plus the header or the
  // returning read entering now. A new read only lands next cycle, so it is
  // safe whenever this stays below 2; counting the pop keeps the stream at
  // one word per cycle with tx_ready high.
  assign room = 3'(occ) + 3'(in_hdr) + 3'(rd_vld_p1) - 3'(pop);

  assign buffer_rd_en = (in_hdr | in_pay) && (cur_issued < cur_len) && (room < 3'd2);

  // Header and returning data never coincide: all reads of the previous
  // packet have landed before its last word can be accepted.
  assign push      = in_hdr | rd_vld_p1;
  assign push_data = in_hdr ? DATA_W'(build_hdr(HDR_MAGIC, pkt_idx, hdr_len, remaining))
                            : buffer_rd_data;
  assign push_last = in_hdr ? 1'b0 : rd_last_p1;

  // Only payload words carry last, so this marks the end of a packet.
  assign last_acc = pop & tx.tx_last;

  tx_skid_fifo2 #(.DATA_W(DATA_W)) u_skid (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .push      (push),
    .push_data (push_data),
    .push_last (push_last),
    .pop       (pop),
    .out_valid (tx.tx_valid),
    .out_data  (tx.tx_data),
    .out_last  (tx.tx_last),
    .occupancy (occ)
  );

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      pkt_len    <= '0;
      issued     <= '0;
      pkt_idx    <= '0;
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
      read_start <= 1'b0;
      busy       <= 1'b0;
      frame_sent <= 1'b0;
    end else begin
      read_start <= 1'b0;
      frame_sent <= 1'b0;

      // p0 -> p1: read issued this cycle, word returns next cycle
      rd_vld_p1  <= buffer_rd_en;
      rd_last_p1 <= buffer_rd_en && ((cur_issued + ONE) == cur_len);
      if (buffer_rd_en) begin
        issued <= cur_issued + ONE;
      end

      case (state)
        ST_IDLE: begin
          if (frame_done) begin
            state      <= ST_SNAP;
            read_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_SNAP: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          remaining <= buffer_data_count;
          pkt_idx   <= '0;
          state     <= (buffer_data_count == '0) ? ST_DONE : ST_HDR;
        end
        ST_HDR: begin
          pkt_len <= hdr_len;
          state   <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (last_acc) begin
            remaining <= remaining - pkt_len;
            pkt_idx   <= pkt_idx + 16'd1;
            state     <= (remaining == pkt_len) ? ST_DONE : ST_HDR;
          end
        end
        ST_DONE: begin
          frame_sent <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/feature_tx_ctrl.md
Name: feature_tx_ctrl

Overview:
- Downstream consumer of the feature TX buffer (64-bit FIFO, 13-bit data_count snapshot on read_start, standard-mode read with 1-cycle latency).
- On frame completion, issues read_start, samples the frozen word count, drains exactly that many words and packetises them into a 64-bit valid/ready stream for the Ethernet/UDP TX path.
- Each packet is one header word followed by up to MAX_PKT_WORDS payload words.

Parameters:
- MAX_PKT_WORDS, 128, maximum payload words per packet (1..4095).
- HDR_MAGIC, 16'hA55A, header sync field.

Ports:
- sclk  in  1  clock
- s_rst_n  in  1  asynchronous reset, active-low
- frame_done  in  1  single-cycle pulse: upstream finished writing one frame into the buffer
- read_start  out  1  single-cycle pulse to the buffer: snapshot data_count
- buffer_data_count  in  13  snapshot from the buffer, valid the cycle after read_start
- buffer_rd_en  out  1  FIFO read strobe
- buffer_rd_data  in  64  FIFO data, valid 1 cycle after buffer_rd_en
- tx_data  out  64  stream data
- tx_valid  out  1  stream valid
- tx_last  out  1  last word of the current packet
- tx_ready  in  1  downstream ready
- busy  out  1  high from frame_done acceptance until DONE
- frame_sent  out  1  single-cycle pulse when the whole frame has been sent

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters 0; output skid buffer empty.
- FSM states: IDLE, SNAP, LOAD, HDR, PAYLOAD, DONE.
- IDLE:
  - frame_done=1 → SNAP; busy=1 from the next cycle.
  - frame_done arriving while not IDLE is ignored; it is not queued.
- SNAP: read_start=1 for exactly this cycle → LOAD.
- LOAD:
  - Register total=buffer_data_count and pkt_idx=0.
  - total==0 → DONE, with no stream output.
  - Otherwise → HDR.
- HDR:
  - pkt_len=min(remaining, MAX_PKT_WORDS).
  - Header word = {HDR_MAGIC, pkt_idx[15:0], 3'b0, pkt_len[12:0], 3'b0, remaining[12:0]}, where remaining is the count before this packet.
  - Header is pushed into the skid buffer → PAYLOAD.
- PAYLOAD:
  - Issue buffer_rd_en while words issued < pkt_len AND (skid occupancy + reads in flight) < 2.
  - Each returning word enters the skid buffer one cycle after its rd_en.
  - tx_last=1 on the final payload word of the packet.
  - When the last payload word is accepted (tx_valid&tx_ready): remaining -= pkt_len, pkt_idx++, then remaining==0 → DONE, else → HDR.
- DONE: frame_sent=1 for 1 cycle; busy=0 → IDLE.
- Skid buffer:
  - 2-entry FIFO of {data, last}; tx_valid = not empty.
  - tx_data and tx_last must remain stable while tx_valid & !tx_ready.
- Throughput: with tx_ready held high, one word per cycle after the initial 1-cycle read latency. There is no bubble between header and payload; the first payload read issues in the HDR cycle if the skid buffer has room.
- The block never reads more than total words. buffer_rd_en is never asserted outside PAYLOAD/HDR.
- Width rules:
  - pkt_idx is 16-bit and wraps modulo 2^16.
  - Counters are 13-bit; total is at most 4096, which fits in 13 bits.
- Asynchronous reset mid-frame: return to IDLE immediately and discard skid contents. Residual FIFO words are the buffer's responsibility, since its srst is tied to the same reset.

Decomposition:
- Package feature_tx_pkg: state enum, HDR_MAGIC, header field offsets, count width (13).
- Sub-module tx_skid_fifo2: the 2-entry data/last skid buffer with occupancy output.

Test Plan:
- Count 5, MAX=128, tx_ready=1: read_start 1 cycle after frame_done. Stream is header {A55A,0000,0005,0005} + 5 words, tx_last on word 5, then frame_sent; 6 beats in 7 cycles.
- Count 300, MAX=128: 3 packets with lengths 128/128/44, pkt_idx 0/1/2, remaining fields 300/172/44. Exactly 300 rd_en pulses.
- Count 0: read_start pulses; no tx_valid, no rd_en; frame_sent 2 cycles after the LOAD cycle; busy returns to 0.
- Random tx_ready (50%), count 37: data order preserved against the FIFO model. Stable data while stalled; rd_en never overruns the skid buffer (occupancy + in-flight ≤ 2).
- frame_done pulsed during PAYLOAD: ignored; only one read_start per frame.
- s_rst_n asserted mid-packet: all outputs 0 asynchronously. A new frame_done after release produces a correct header with pkt_idx 0.
